// File: rtl/sbc_ctrl_if.sv
// Control bus between the accumulator-CPU controller and its datapath.
// The controller (master) drives strobes; the datapath (slave) returns status.
interface sbc_ctrl_if;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       halt;
    logic       ld_pc;
    logic       data_c;
    logic       ld_ac;
    logic       wr;
    logic [2:0] phase;
    logic [2:0] opcode;
    logic       zero;

    modport master (
        output sel, rd, ld_ir, inc_pc, halt,
        output ld_pc, data_c, ld_ac, wr,
        input  phase, opcode, zero
    );

    modport slave (
        input  sel, rd, ld_ir, inc_pc, halt,
        input  ld_pc, data_c, ld_ac, wr,
        output phase, opcode, zero
    );
endinterface

// File: rtl/sbc_datapath.sv
// Execution datapath of the 8-phase accumulator CPU: phase counter,
// PC/IR/AC, ALU, 32x8 program/data RAM and run-control FSM.
module sbc_datapath #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    sbc_ctrl_if.slave     ctrl,
    output logic          halted,
    output logic          running,
    output logic [AW-1:0] pc_out,
    output logic [DW-1:0] ac_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          run;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem [2**AW];

    logic [2:0]    ph;
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic [DW-1:0] ac;
    logic [AW-1:0] addr;
    logic [DW-1:0] bus;
    logic [DW-1:0] alu;

    // Run-control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state: start launches from IDLE or HALT, halt ends a run.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start)     state_nxt = S_RUN;
            S_RUN:   if (ctrl.halt) state_nxt = S_HALT;
            S_HALT:  if (start)     state_nxt = S_RUN;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs and RAM write-port steering (program port only when not running).
    always_comb begin
        run       = (state == S_RUN);
        running   = run;
        halted    = (state == S_HALT);
        mem_we    = prog_we;
        mem_waddr = prog_addr;
        mem_wdata = prog_data;
        if (run) begin
            mem_we    = ctrl.wr;
            mem_waddr = addr;
            mem_wdata = ac;
        end
    end

    // Address mux, data bus (RAM read beats AC) and ALU.
    always_comb begin
        addr = ctrl.sel ? pc : ir[AW-1:0];
        bus  = '0;
        if (ctrl.rd)          bus = mem[addr];
        else if (ctrl.data_c) bus = ac;
        unique case (ir[DW-1 -: 3])
            3'b010:  alu = ac + bus;
            3'b011:  alu = ac & bus;
            3'b100:  alu = ac ^ bus;
            3'b101:  alu = bus;
            default: alu = ac;
        endcase
    end

    // RAM is deliberately not reset; writes gated by FSM state above.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Architectural registers; start from IDLE/HALT rewinds PC only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= '0;
            pc <= '0;
            ir <= '0;
            ac <= '0;
        end else if (run) begin
            ph <= ctrl.halt ? 3'd0 : ph + 3'd1;
            if (ctrl.ld_ir) ir <= bus;
            if (ctrl.ld_ac) ac <= alu;
            if (ctrl.ld_pc)       pc <= ir[AW-1:0];
            else if (ctrl.inc_pc) pc <= pc + 1'b1;
        end else begin
            ph <= '0;
            if (start) pc <= '0;
        end
    end

    assign ctrl.phase  = ph;
    assign ctrl.opcode = ir[DW-1 -: 3];
    assign ctrl.zero   = (ac == '0);
    assign pc_out      = pc;
    assign ac_out      = ac;

endmodule

// File: doc/sbc_datapath.md
Name: sbc_datapath

Overview:
- Execution datapath for the 8-phase accumulator CPU. It is the consumer end of the controller's control bus: it takes sel, rd, ld_ir, inc_pc, halt, ld_pc, data_c, ld_ac and wr, and returns phase, opcode and zero.
- Contains the phase counter, PC, IR, AC, ALU, a 32x8 program/data RAM, and a run-control FSM with a program-load port.
- Sits beside the controller in the CPU top level.

Parameters:
- AW, 5, address width (PC, IR operand field, RAM depth 2**AW).
- DW, 8, data width. Opcode is always IR[DW-1:DW-3]; operand is IR[AW-1:0].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins execution at PC=0.
- prog_we  in  1  program-load write strobe.
- prog_addr  in  AW  program-load address.
- prog_data  in  DW  program-load data.
- sel  in  1  from controller: 1 = PC drives memory address, 0 = IR[AW-1:0] drives it.
- rd  in  1  from controller: RAM read onto the internal data bus.
- ld_ir  in  1  from controller: IR <= data bus.
- inc_pc  in  1  from controller: PC <= PC+1.
- halt  in  1  from controller: stop execution.
- ld_pc  in  1  from controller: PC <= IR[AW-1:0].
- data_c  in  1  from controller: AC drives the data bus.
- ld_ac  in  1  from controller: AC <= ALU result.
- wr  in  1  from controller: RAM[addr] <= AC.
- phase  out  3  current instruction phase, to controller.
- opcode  out  3  IR[DW-1:DW-3], to controller.
- zero  out  1  AC == 0, to controller.
- halted  out  1  high in HALT state.
- running  out  1  high in RUN state.
- pc_out  out  AW  current PC (observation).
- ac_out  out  DW  current AC (observation).

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; phase=0, PC=0, IR=0, AC=0; halted=0, running=0.
  - RAM contents are not reset.
  - Reset mid-RUN aborts immediately. No write is completed on or after the edge where rst_n is low.
- FSM IDLE:
  - phase held at 0; all controller inputs ignored.
  - prog_we=1 writes prog_data to RAM[prog_addr] on the edge.
  - start=1 -> RUN, with PC<=0 and phase<=0.
  - If start and prog_we are sampled together, the write is performed and then the transition to RUN is taken.
- FSM RUN:
  - phase <= phase+1 every cycle, wrapping 7->0.
  - prog_we and start are ignored.
  - halt=1 sampled on an edge -> HALT; phase<=0; the inc_pc sampled on that same edge still takes effect.
- FSM HALT:
  - halted=1; PC, AC and IR frozen; phase=0.
  - prog_we is honoured.
  - start=1 -> RUN with PC<=0, phase<=0. AC and IR are retained.
- Memory address: sel ? PC : IR[AW-1:0].
- Data bus: RAM[addr] when rd=1 (combinational read); AC when data_c=1. If both are asserted, rd wins.
- RAM write: on the edge with wr=1 in RUN; RAM[addr] <= AC.
- ALU, combinational on opcode; data = data bus:
  - 010 ADD: AC+data, modulo 2**DW, carry discarded.
  - 011 AND: AC&data.
  - 100 XOR: AC^data.
  - 101 LDA: data.
  - all other opcodes: AC (pass through).
- Register updates in RUN, all on the same edge:
  - IR <= bus if ld_ir.
  - AC <= ALU if ld_ac.
  - PC: ld_pc has priority over inc_pc. PC+1 wraps 2**AW-1 -> 0.
- zero and opcode are combinational from AC and IR, so the controller sees the updated values in the next phase.

Test Plan:
- Load RAM[0..3]={0xB0,0x51,0xD2,0x00} and RAM[0x10]=3, RAM[0x11]=4; pulse start -> halted rises 29 cycles after the start edge; AC=7, RAM[0x12]=7, pc_out=4, phase=0.
- Load {0xB0,0x20,0x00,0x00} with RAM[0x10]=0 (LDA 0, SKZ, HLT@2, HLT@3); run -> SKZ skips, halt occurs at the PC=3 instruction, final pc_out=4.
- Load JMP 0x05 (0xE5) at 0 and HLT at 5; run -> pc_out=6 at halt; instructions at addresses 1-4 are never fetched.
- Load RAM[0x10]=0xFF, program {0xB0, 0x50 (ADD 0x10), 0x00}; run -> AC=0xFE (carry dropped), zero=0. PC-wrap case: JMP 0x1F with HLT at 0x1F -> pc_out wraps to 0.
- Assert rst_n=0 mid-RUN at phase 6 of a STO -> outputs return to reset values immediately and the RAM target is unchanged. prog_we pulses during RUN -> RAM is unchanged.
- In HALT, pulse start -> running=1 and PC=0 on the next cycle, AC is retained, and the program re-executes to the same result.
